transmitter_txd: RTL and testbench

//  Serial transmit half of the lab UART link: the TX end of the frame that the RX path deserialises bit-by-bit.

---
 rtl/uart_pkg.sv | 17 +
 rtl/baud_tick_gen.sv | 29 ++
 rtl/transmitter_txd.sv | 111 +++++++++++
 tb/tb_transmitter_txd.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the lab UART transmit/receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS = 8;

  function automatic int bit_cycles(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts 0..BIT_CYCLES-1 and flags the last cycle of each bit.
module baud_tick_gen #(
  parameter int BIT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt_r;

  // Counter register, held at zero while cleared and wrapping after the last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CW'(0);
    end else if (clr || (cnt_r == LAST)) begin
      cnt_r <= CW'(0);
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign tick = (cnt_r == LAST);

endmodule

// File: rtl/transmitter_txd.sv
// UART transmitter: one byte per send handshake, shifted out as an 8N1 frame on txd.
module transmitter_txd
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9_600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send,
  input  logic [7:0] data,
  output logic       rdy,
  output logic       txd,
  output logic       txen
);

  localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD);
  localparam int BCW        = $clog2(DATA_BITS);

  generate
    if (BIT_CYCLES < 2) begin : g_bit_cycles_check
      $error("transmitter_txd: CLK_FREQ/BAUD must be at least 2");
    end
  endgenerate

  tx_state_t            state_r, next_state_s;
  logic [DATA_BITS-1:0] shreg_r, next_shreg_s;
  logic [BCW-1:0]       bit_cnt_r, next_bit_cnt_s;
  logic                 txd_r, rdy_r, txen_r, next_txd_s;
  logic                 tick_s, clr_s;

  assign clr_s = (state_r == IDLE);

  baud_tick_gen #(.BIT_CYCLES(BIT_CYCLES)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .tick  (tick_s)
  );

  // Next-state, shift and line-level decode.
  always_comb begin
    next_state_s   = state_r;
    next_shreg_s   = shreg_r;
    next_bit_cnt_s = bit_cnt_r;
    next_txd_s     = 1'b1;
    case (state_r)
      IDLE: begin
        if (send) begin
          next_state_s   = START;
          next_shreg_s   = data;
          next_bit_cnt_s = BCW'(0);
        end else begin
          next_state_s = IDLE;
        end
      end
      START: begin
        if (tick_s) next_state_s = DATA;
        else        next_state_s = START;
      end
      DATA: begin
        if (tick_s) begin
          next_shreg_s   = {1'b0, shreg_r[DATA_BITS-1:1]};
          next_bit_cnt_s = bit_cnt_r + BCW'(1);
          if (bit_cnt_r == BCW'(DATA_BITS - 1)) next_state_s = STOP;
          else                                  next_state_s = DATA;
        end else begin
          next_state_s = DATA;
        end
      end
      STOP: begin
        if (tick_s) next_state_s = IDLE;
        else        next_state_s = STOP;
      end
      default: next_state_s = IDLE;
    endcase

    // txd is registered, so it is decoded from where the FSM is heading.
    case (next_state_s)
      IDLE:    next_txd_s = 1'b1;
      START:   next_txd_s = 1'b0;
      DATA:    next_txd_s = next_shreg_s[0];
      STOP:    next_txd_s = 1'b1;
      default: next_txd_s = 1'b1;
    endcase
  end

  // State, datapath and registered line outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      shreg_r   <= {DATA_BITS{1'b0}};
      bit_cnt_r <= BCW'(0);
      txd_r     <= 1'b1;
      rdy_r     <= 1'b1;
      txen_r    <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      shreg_r   <= next_shreg_s;
      bit_cnt_r <= next_bit_cnt_s;
      txd_r     <= next_txd_s;
      rdy_r     <= (next_state_s == IDLE);
      txen_r    <= (next_state_s != IDLE);
    end
  end

  assign txd  = txd_r;
  assign rdy  = rdy_r;
  assign txen = txen_r;

endmodule

// File: tb/tb_transmitter_txd.sv
// Directed bench for transmitter_txd with BIT_CYCLES = 16.
module tb_transmitter_txd;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       send  = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       rdy;
  logic       txd;
  logic       txen;

  int checks = 0;
  int errors = 0;

  transmitter_txd #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .send  (send),
    .data  (data),
    .rdy   (rdy),
    .txd   (txd),
    .txen  (txen)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected line: each frame bit held for 16 clocks, frame bit j in f[j].
  function automatic logic [159:0] expand(input logic [9:0] f);
    logic [159:0] r;
    for (int i = 0; i < 160; i++) r[i] = f[i / 16];
    return r;
  endfunction

  function automatic logic [9:0] midbits(input logic [159:0] line);
    logic [9:0] r;
    for (int j = 0; j < 10; j++) r[j] = line[16 * j + 8];
    return r;
  endfunction

  // Records txd after edges k..k+159 (caller is just past accepting edge k).
  task automatic capture(output logic [159:0] line, output int rdy_hi, output int txen_lo,
                         input int chg_at, input logic [7:0] chg_data, input int pulse_at);
    rdy_hi  = 0;
    txen_lo = 0;
    line    = '0;
    for (int c = 0; c < 160; c++) begin
      if (c > 0) cyc(1);
      line[c] = txd;
      if (rdy)   rdy_hi++;
      if (!txen) txen_lo++;
      if (c == chg_at) data = chg_data;
      if (pulse_at >= 0) begin
        if (c == pulse_at)          send = 1'b1;
        else if (c == pulse_at + 1) send = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    cyc(5);
    checks++;
    if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", rdy); end
    checks++;
    if (txen !== 1'b0) begin errors++; $display("FAIL reset_txen: got %b expected 0", txen); end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      checks++;
      if ({txd, rdy, txen} !== 3'b110) begin
        errors++;
        $display("FAIL idle_after_reset cyc %0d: got txd/rdy/txen=%b expected 110", i, {txd, rdy, txen});
      end
    end
  endtask

  task automatic test_frame_55;
    logic [159:0] line;
    int rh, tl;
    data = 8'h55;
    send = 1'b1;
    cyc(1);
    send = 1'b0;
    checks++;
    if ({txd, rdy, txen} !== 3'b001) begin
      errors++;
      $display("FAIL f55_accept: got txd/rdy/txen=%b expected 001", {txd, rdy, txen});
    end
    capture(line, rh, tl, -1, 8'h00, -1);
    checks++;
    if (midbits(line) !== 10'b1010101010) begin
      errors++;
      $display("FAIL f55_midbits: got %b expected %b", midbits(line), 10'b1010101010);
    end
    checks++;
    if (line !== expand(10'b1010101010)) begin
      errors++;
      $display("FAIL f55_timing: got %h expected %h", line, expand(10'b1010101010));
    end
    checks++;
    if (rh !== 0 || tl !== 0) begin
      errors++;
      $display("FAIL f55_flags: got rdy_hi=%0d txen_lo=%0d expected 0 0", rh, tl);
    end
    cyc(1);
    checks++;
    if ({txd, rdy, txen} !== 3'b110) begin
      errors++;
      $display("FAIL f55_end: got txd/rdy/txen=%b expected 110 at edge k+160", {txd, rdy, txen});
    end
  endtask

  task automatic test_data_change;
    logic [159:0] line;
    int rh, tl;
    data = 8'hA3;
    send = 1'b1;
    cyc(1);
    send = 1'b0;
    capture(line, rh, tl, 40, 8'hFF, 50);
    checks++;
    if (line !== expand(10'b1101000110)) begin
      errors++;
      $display("FAIL a3_line: got %h expected %h", line, expand(10'b1101000110));
    end
    checks++;
    if (rh !== 0 || tl !== 0) begin
      errors++;
      $display("FAIL a3_flags: got rdy_hi=%0d txen_lo=%0d expected 0 0", rh, tl);
    end
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      checks++;
      if ({txd, rdy, txen} !== 3'b110) begin
        errors++;
        $display("FAIL a3_no_second_frame cyc %0d: got txd/rdy/txen=%b expected 110", i, {txd, rdy, txen});
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [159:0] line;
    int rh, tl;
    data = 8'h00;
    send = 1'b1;
    cyc(1);
    data = 8'hFF;
    capture(line, rh, tl, -1, 8'h00, -1);
    checks++;
    if (line !== expand(10'b1000000000)) begin
      errors++;
      $display("FAIL b2b_first: got %h expected %h", line, expand(10'b1000000000));
    end
    cyc(1);
    checks++;
    if ({txd, rdy, txen} !== 3'b110) begin
      errors++;
      $display("FAIL b2b_gap: got txd/rdy/txen=%b expected 110", {txd, rdy, txen});
    end
    cyc(1);
    checks++;
    if ({txd, rdy, txen} !== 3'b001) begin
      errors++;
      $display("FAIL b2b_second_start: got txd/rdy/txen=%b expected 001 at edge k+161", {txd, rdy, txen});
    end
    send = 1'b0;
    capture(line, rh, tl, -1, 8'h00, -1);
    checks++;
    if (line !== expand(10'b1111111110)) begin
      errors++;
      $display("FAIL b2b_second: got %h expected %h", line, expand(10'b1111111110));
    end
    cyc(1);
    checks++;
    if ({txd, rdy, txen} !== 3'b110) begin
      errors++;
      $display("FAIL b2b_end: got txd/rdy/txen=%b expected 110", {txd, rdy, txen});
    end
  endtask

  task automatic test_reset_midframe;
    logic [159:0] line;
    int rh, tl;
    data = 8'hC3;
    send = 1'b1;
    cyc(1);
    send = 1'b0;
    cyc(70);
    // Edge k+70 is inside data bit 3 of C3, which is 0.
    checks++;
    if (txd !== 1'b0) begin errors++; $display("FAIL mid_prereset_txd: got %b expected 0", txd); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({txd, rdy, txen} !== 3'b110) begin
      errors++;
      $display("FAIL mid_async_reset: got txd/rdy/txen=%b expected 110", {txd, rdy, txen});
    end
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    checks++;
    if ({txd, rdy, txen} !== 3'b110) begin
      errors++;
      $display("FAIL mid_after_release: got txd/rdy/txen=%b expected 110", {txd, rdy, txen});
    end
    data = 8'h0F;
    send = 1'b1;
    cyc(1);
    send = 1'b0;
    capture(line, rh, tl, -1, 8'h00, -1);
    checks++;
    if (line !== expand(10'b1000011110)) begin
      errors++;
      $display("FAIL f0f_line: got %h expected %h", line, expand(10'b1000011110));
    end
    cyc(1);
    checks++;
    if ({txd, rdy, txen} !== 3'b110) begin
      errors++;
      $display("FAIL f0f_end: got txd/rdy/txen=%b expected 110", {txd, rdy, txen});
    end
  endtask

  initial begin
    test_reset();
    test_frame_55();
    test_data_change();
    test_back_to_back();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
